// File: rtl/vend_pkg.sv
// Shared vending coin-path definitions: payout FSM states, coin units, acceptor states.
package vend_pkg;

  // Payout FSM state encodings
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    REQ   = 3'b001,
    REL   = 3'b010,
    DONE  = 3'b011,
    FAULT = 3'b100
  } pay_state_e;

  // Coin values in units of 50
  localparam int unsigned UNIT50  = 1;
  localparam int unsigned UNIT100 = 2;

  // Coin-acceptor credit states, kept here so credit widths stay consistent
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S50  = 3'd1,
    S100 = 3'd2,
    S150 = 3'd3,
    S200 = 3'd4
  } acc_state_e;

endpackage

// File: rtl/change_timeout_ctr.sv
// Per-phase handshake timer.
//   clk, rst      : clock, async active-low reset
//   clr           : synchronous clear (wins over en)
//   en            : count up one per cycle
//   expire_c      : count has reached TIMEOUT-1 (combinational from the register)
module change_timeout_ctr #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [CW-1:0] count_q;

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count_q <= '0;
    else if (clr)   count_q <= '0;
    else if (en)    count_q <= count_q + CW'(1);
  end

  assign expire_c = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Change/refund payout through a coin hopper with a 4-phase req/ack handshake.
//   clk, rst        : clock, async active-low reset
//   start           : pay-out request, accepted only in IDLE
//   credit, price   : amounts in units of 50, sampled with start
//   hopper_ack      : hopper acknowledge
//   clear           : leave FAULT
//   coin100_req     : request one 100-coin
//   coin50_req      : request one 50-coin
//   busy            : not IDLE
//   done            : one-cycle completion pulse
//   short_flag      : last accepted start was a full refund (credit < price)
//   fault           : handshake timed out
//   state           : current FSM state encoding
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned W       = 3,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CW      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] credit,
  input  logic [W-1:0] price,
  input  logic         hopper_ack,
  input  logic         clear,
  output logic         coin100_req,
  output logic         coin50_req,
  output logic         busy,
  output logic         done,
  output logic         short_flag,
  output logic         fault,
  output logic [2:0]   state
);

  pay_state_e   state_q, state_d;
  logic [W-1:0] remain_q, remain_d;
  logic [W-1:0] amount_c;
  logic         c100_d, c50_d, short_d;
  logic         tmr_clr_c, tmr_en_c, expire_c;

  change_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .expire_c (expire_c)
  );

  // Next state, remain and request selection
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    c100_d   = 1'b0;
    c50_d    = 1'b0;
    short_d  = short_flag;
    amount_c = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract only when it cannot wrap; otherwise refund the whole credit
          if (credit >= price) begin
            amount_c = credit - price;
            short_d  = 1'b0;
          end else begin
            amount_c = credit;
            short_d  = 1'b1;
          end
          remain_d = amount_c;
          if (amount_c == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            c100_d  = (amount_c >= W'(UNIT100));
            c50_d   = (amount_c <  W'(UNIT100));
          end
        end
      end
      REQ: begin
        // Ack has priority over a timeout on the same edge
        if (hopper_ack) begin
          remain_d = remain_q - (coin100_req ? W'(UNIT100) : W'(UNIT50));
          state_d  = REL;
        end else if (expire_c) begin
          state_d = FAULT;
        end else begin
          c100_d = coin100_req;
          c50_d  = coin50_req;
        end
      end
      REL: begin
        if (!hopper_ack) begin
          if (remain_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            c100_d  = (remain_q >= W'(UNIT100));
            c50_d   = (remain_q <  W'(UNIT100));
          end
        end else if (expire_c) begin
          state_d = FAULT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer runs in the handshake phases and restarts on every phase change
  assign tmr_en_c  = (state_q == REQ) || (state_q == REL);
  assign tmr_clr_c = (state_d != state_q) || !tmr_en_c;

  // State, remain and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      coin100_req <= 1'b0;
      coin50_req  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      short_flag  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      coin100_req <= c100_d;
      coin50_req  <= c50_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      short_flag  <= short_d;
      fault       <= (state_d == FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random payouts
// checked against a coin-list model (remain/2 hundreds, then remain%2 fifties).
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] credit;
  logic [2:0] price;
  logic       hopper_ack;
  logic       clear;
  logic       coin100_req;
  logic       coin50_req;
  logic       busy;
  logic       done;
  logic       short_flag;
  logic       fault;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  // hopper model controls
  bit hop_en    = 1'b0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int obs[$];
  int done_cnt  = 0;

  change_dispenser #(.W(3), .TIMEOUT(8), .CW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .credit      (credit),
    .price       (price),
    .hopper_ack  (hopper_ack),
    .clear       (clear),
    .coin100_req (coin100_req),
    .coin50_req  (coin50_req),
    .busy        (busy),
    .done        (done),
    .short_flag  (short_flag),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hopper: acknowledges a request after ack_delay cycles, releases when req drops
  always @(negedge clk) begin
    if (!hop_en || !rst) begin
      hopper_ack = 1'b0;
      wait_cnt   = 0;
    end else if ((coin100_req || coin50_req) && !hopper_ack) begin
      if (wait_cnt >= ack_delay) begin
        hopper_ack = 1'b1;
        wait_cnt   = 0;
        obs.push_back(coin100_req ? 2 : 1);
      end else begin
        wait_cnt++;
      end
    end else if (!(coin100_req || coin50_req) && hopper_ack) begin
      hopper_ack = 1'b0;
    end
  end

  // Continuous protocol checks: requests one-hot and only while in REQ
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done) done_cnt++;
      n_assert++;
      assert ((state == 3'd1) === (coin100_req ^ coin50_req)) else begin
        n_fail++;
        $error("FAIL req_onehot: observed state=%0d c100=%0b c50=%0b expected one req only in REQ",
               state, coin100_req, coin50_req);
      end
    end
  end

  // Bounded safety net
  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish expected finish before limit");
    $fatal(1, "watchdog expired");
  end

  // One payout transaction checked against the coin-list model
  task automatic run_txn(input int c, input int p, input int dly, input bit noise);
    int  rem, lat;
    bit  exp_short, seen;
    int  exp_q[$];
    obs.delete();
    done_cnt  = 0;
    ack_delay = dly;
    hop_en    = 1'b1;
    exp_short = (c < p);
    rem       = exp_short ? c : c - p;
    for (int i = 0; i < rem / 2; i++) exp_q.push_back(2);
    if (rem % 2 == 1) exp_q.push_back(1);

    credit = 3'(c);
    price  = 3'(p);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    lat   = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise && (state == 3'd1 || state == 3'd2) && $urandom_range(0, 2) == 0) begin
        credit = 3'($urandom_range(0, 7));
        price  = 3'($urandom_range(0, 7));
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      lat++;
    end
    check($sformatf("done_seen c=%0d p=%0d", c, p), 32'(seen), 32'd1);
    if (rem == 0) check("zero_change_latency", 32'(lat), 32'd0);
    check("done_state", 32'(state), 32'd3);
    check("done_short_flag", 32'(short_flag), 32'(exp_short));
    @(negedge clk);
    check("post_state_idle", 32'(state), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_done_low", 32'(done), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("short_flag_held", 32'(short_flag), 32'(exp_short));
    check($sformatf("coin_count c=%0d p=%0d", c, p), 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("coin_%0d c=%0d p=%0d", i, c, p), 32'(obs[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    credit = '0;
    price  = '0;
    clear  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reqs", 32'({coin100_req, coin50_req}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_short", 32'(short_flag), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed payouts
    run_txn(4, 3, 1, 1'b0);   // one 50
    run_txn(7, 2, 0, 1'b0);   // 100, 100, 50
    run_txn(1, 3, 0, 1'b0);   // refund 50, short
    run_txn(3, 3, 0, 1'b0);   // zero change
    run_txn(7, 0, 2, 1'b1);   // starts while busy are ignored

    // timeout: hopper silent
    hop_en = 1'b0;
    credit = 3'd7;
    price  = 3'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("timeout_req_%0d", i), 32'(coin100_req), 32'd1);
      @(negedge clk);
    end
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_state", 32'(state), 32'd4);
    check("timeout_req_low", 32'({coin100_req, coin50_req}), 32'd0);
    check("timeout_busy", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fault_ignores_start", 32'(state), 32'd4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_state", 32'(state), 32'd0);
    check("clear_fault", 32'(fault), 32'd0);

    // asynchronous reset mid-REQ
    credit = 3'd6;
    price  = 3'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_req", 32'(coin100_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(coin100_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_idle", 32'(state), 32'd0);

    // random payouts
    for (int t = 0; t < 14; t++)
      run_txn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
